// File: rtl/reg_wb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package reg_wb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2
    } src_t;
endpackage

// File: rtl/reg_wb_arbiter_slot.sv
// One-entry holding slot (valid/addr/data/age) with valid/ready input side.
module wb_hold_slot #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter bit TIE_YOUNG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic              grant_i,
    input  logic              peer_hold_i,
    input  logic              peer_load_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              young_o
);
    logic              valid_q, valid_d;
    logic              young_q, young_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              load;

    // Handshake: ready depends only on slot state and grant, never on in_valid_i;
    // a transfer happens on the rising edge where in_valid_i && in_ready_o.
    assign in_ready_o = !rst && (!valid_q || grant_i);
    assign load       = in_valid_i && in_ready_o;

    // young = some other entry still held in the peer slot was captured before this one.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        young_d = young_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = in_addr_i;
            data_d  = in_data_i;
            young_d = peer_hold_i || (peer_load_i && TIE_YOUNG);
        end else if (grant_i) begin
            valid_d = 1'b0;
            young_d = 1'b0;
        end else begin
            young_d = young_q && peer_hold_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            young_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            young_q <= young_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign young_o = young_q;
endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter merging ALU and load results onto the register-file write port.
// Optional same-cycle read bypass enabled by defining WB_BYPASS_EN.
module reg_wb_arbiter #(
    parameter int DATA_W       = reg_wb_pkg::DATA_W,
    parameter int ADDR_W       = reg_wb_pkg::ADDR_W,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              w_e3,
    output logic [ADDR_W-1:0] w_a3,
    output logic [DATA_W-1:0] w_d,
    input  logic [ADDR_W-1:0] r_a1,
    input  logic [ADDR_W-1:0] r_a2,
    input  logic [DATA_W-1:0] rf_d1,
    input  logic [DATA_W-1:0] rf_d2,
    output logic [DATA_W-1:0] r_d1,
    output logic [DATA_W-1:0] r_d2
);
    import reg_wb_pkg::*;

    logic              alu_v, ld_v, alu_young, ld_young;
    logic [ADDR_W-1:0] alu_a, ld_a;
    logic [DATA_W-1:0] alu_dq, ld_dq;
    logic              gnt_alu, gnt_ld;
    src_t              sel;
    logic [3:0]        starve_q, starve_d;
    logic              w_e3_q, w_e3_d;
    logic [ADDR_W-1:0] w_a3_q, w_a3_d;
    logic [DATA_W-1:0] w_d_q, w_d_d;

    wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIE_YOUNG(1'b1)) u_alu_slot (
        .clk(clk), .rst(rst),
        .in_valid_i(alu_valid), .in_addr_i(alu_addr), .in_data_i(alu_data),
        .in_ready_o(alu_ready), .grant_i(gnt_alu),
        .peer_hold_i(ld_v && !gnt_ld), .peer_load_i(ld_valid && ld_ready),
        .valid_o(alu_v), .addr_o(alu_a), .data_o(alu_dq), .young_o(alu_young)
    );

    wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIE_YOUNG(1'b0)) u_ld_slot (
        .clk(clk), .rst(rst),
        .in_valid_i(ld_valid), .in_addr_i(ld_addr), .in_data_i(ld_data),
        .in_ready_o(ld_ready), .grant_i(gnt_ld),
        .peer_hold_i(alu_v && !gnt_alu), .peer_load_i(alu_valid && alu_ready),
        .valid_o(ld_v), .addr_o(ld_a), .data_o(ld_dq), .young_o(ld_young)
    );

    // Same destination: age decides (WAW); otherwise starvation, then load priority.
    always_comb begin
        sel = SRC_NONE;
        if (alu_v && ld_v) begin
            if (alu_a == ld_a)
                sel = (ld_young && !alu_young) ? SRC_ALU : SRC_LD;
            else if (starve_q == 4'(STARVE_LIMIT))
                sel = SRC_ALU;
            else
                sel = SRC_LD;
        end else if (alu_v) begin
            sel = SRC_ALU;
        end else if (ld_v) begin
            sel = SRC_LD;
        end
    end

    assign gnt_alu = (sel == SRC_ALU);
    assign gnt_ld  = (sel == SRC_LD);

    always_comb begin
        starve_d = starve_q;
        if (!alu_v || gnt_alu)
            starve_d = 4'd0;
        else if (starve_q < 4'(STARVE_LIMIT))
            starve_d = starve_q + 4'd1;
    end

    always_comb begin
        w_e3_d = 1'b0;
        w_a3_d = w_a3_q;
        w_d_d  = w_d_q;
        if (gnt_alu) begin
            w_a3_d = alu_a;
            w_d_d  = alu_dq;
            w_e3_d = (alu_a != ADDR_W'(REG_ZERO));
        end else if (gnt_ld) begin
            w_a3_d = ld_a;
            w_d_d  = ld_dq;
            w_e3_d = (ld_a != ADDR_W'(REG_ZERO));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 4'd0;
            w_e3_q   <= 1'b0;
            w_a3_q   <= '0;
            w_d_q    <= '0;
        end else begin
            starve_q <= starve_d;
            w_e3_q   <= w_e3_d;
            w_a3_q   <= w_a3_d;
            w_d_q    <= w_d_d;
        end
    end

    assign w_e3 = w_e3_q;
    assign w_a3 = w_a3_q;
    assign w_d  = w_d_q;

`ifdef WB_BYPASS_EN
    assign r_d1 = (w_e3_q && (w_a3_q == r_a1) && (r_a1 != ADDR_W'(REG_ZERO))) ? w_d_q : rf_d1;
    assign r_d2 = (w_e3_q && (w_a3_q == r_a2) && (r_a2 != ADDR_W'(REG_ZERO))) ? w_d_q : rf_d2;
`else
    logic unused_raddr;
    assign unused_raddr = ^{r_a1, r_a2};
    assign r_d1 = rf_d1;
    assign r_d2 = rf_d2;
`endif
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboarded bench for reg_wb_arbiter: directed vectors, expected writes queued, monitor pops.
module tb_reg_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0, ld_valid = 1'b0;
    logic          alu_ready, ld_ready;
    logic [AW-1:0] alu_addr = '0, ld_addr = '0;
    logic [DW-1:0] alu_data = '0, ld_data = '0;
    logic          w_e3;
    logic [AW-1:0] w_a3;
    logic [DW-1:0] w_d;
    logic [AW-1:0] r_a1 = '0, r_a2 = '0;
    logic [DW-1:0] rf_d1 = '0, rf_d2 = '0;
    logic [DW-1:0] r_d1, r_d2;

    logic [AW+DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    reg_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .w_e3(w_e3), .w_a3(w_a3), .w_d(w_d),
        .r_a1(r_a1), .r_a2(r_a2), .rf_d1(rf_d1), .rf_d2(rf_d2),
        .r_d1(r_d1), .r_d2(r_d2)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Drivers: hold valid until the slot accepts (bounded)
    task automatic send_alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done = 1'b0;
        alu_valid = 1'b1; alu_addr = a; alu_data = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk); done = alu_ready;
            @(posedge clk); #1;
        end
        alu_valid = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL alu_accept_timeout: addr %0d not accepted in 50 cycles", a);
        end
    endtask

    task automatic send_ld(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done = 1'b0;
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk); done = ld_ready;
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL ld_accept_timeout: addr %0d not accepted in 50 cycles", a);
        end
    endtask

    // Scoreboard monitor: every write on the port must match the queue head
    always @(negedge clk) begin
        if (w_e3) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL wb_unexpected: got write a3=%0d d=%h, required no write", w_a3, w_d);
            end else begin
                check("wb_write", 64'({w_a3, w_d}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // 1: reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_w_e3", 64'(w_e3), 64'd0);
        check("rst_w_a3", 64'(w_a3), 64'd0);
        check("rst_w_d", 64'(w_d), 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_ld_ready", 64'(ld_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_alu_ready", 64'(alu_ready), 64'd1);
        check("post_rst_ld_ready", 64'(ld_ready), 64'd1);
        @(posedge clk); #1;

        // 2: single ALU write, latency 1
        push_exp(5'd1, 32'h2100_00CA);
        send_alu(5'd1, 32'h2100_00CA);
        @(posedge clk); #1;
        check("single_w_e3", 64'(w_e3), 64'd1);
        check("single_w_a3", 64'(w_a3), 64'd1);
        check("single_w_d", 64'(w_d), 64'h2100_00CA);
        repeat (3) @(posedge clk); #1;

        // 3: collision, load first then ALU
        push_exp(5'd4, 32'h22);
        push_exp(5'd3, 32'h11);
        fork
            send_alu(5'd3, 32'h11);
            send_ld(5'd4, 32'h22);
        join
        @(posedge clk); #1;
        check("coll_first_a3", 64'(w_a3), 64'd4);
        @(posedge clk); #1;
        check("coll_second_e3", 64'(w_e3), 64'd1);
        check("coll_second_a3", 64'(w_a3), 64'd3);
        repeat (3) @(posedge clk); #1;

        // 4: starvation, ALU forced after three load wins
        push_exp(5'd6, 32'h66);
        push_exp(5'd7, 32'h77);
        push_exp(5'd8, 32'h88);
        push_exp(5'd5, 32'h55);
        push_exp(5'd9, 32'h99);
        fork
            send_alu(5'd5, 32'h55);
            begin
                send_ld(5'd6, 32'h66);
                send_ld(5'd7, 32'h77);
                send_ld(5'd8, 32'h88);
                send_ld(5'd9, 32'h99);
            end
        join
        repeat (6) @(posedge clk); #1;

        // 5: WAW, load captured first then ALU to same register
        push_exp(5'd7, 32'hAA);
        push_exp(5'd7, 32'hBB);
        send_ld(5'd7, 32'hAA);
        send_alu(5'd7, 32'hBB);
        repeat (4) @(posedge clk); #1;

        // 5b: older ALU entry beats a younger load to the same register
        push_exp(5'd6, 32'h61);
        push_exp(5'd5, 32'h51);
        push_exp(5'd5, 32'h52);
        fork
            send_alu(5'd5, 32'h51);
            begin
                send_ld(5'd6, 32'h61);
                send_ld(5'd5, 32'h52);
            end
        join
        repeat (5) @(posedge clk); #1;

        // 6a: write to $0 is consumed but never reaches the port
        send_alu(5'd0, 32'h1234);
        @(posedge clk); #1;
        check("zero_w_e3", 64'(w_e3), 64'd0);
        check("zero_alu_ready", 64'(alu_ready), 64'd1);
        repeat (2) @(posedge clk); #1;

        // 6b: read bypass
        r_a1 = 5'd2; rf_d1 = 32'hDEAD_0001;
        r_a2 = 5'd9; rf_d2 = 32'hBEEF_0002;
        push_exp(5'd2, 32'h55);
        send_alu(5'd2, 32'h55);
        @(posedge clk); #1;
        check("byp_w_e3", 64'(w_e3), 64'd1);
`ifdef WB_BYPASS_EN
        check("byp_r_d1", 64'(r_d1), 64'h55);
`else
        check("byp_r_d1", 64'(r_d1), 64'hDEAD_0001);
`endif
        check("byp_r_d2", 64'(r_d2), 64'hBEEF_0002);
        @(posedge clk); #1;
        check("byp_idle_r_d1", 64'(r_d1), 64'hDEAD_0001);
        repeat (2) @(posedge clk); #1;

        // Reset mid-operation: both slots full, no write may follow
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA0A0;
        ld_valid  = 1'b1; ld_addr  = 5'd11; ld_data  = 32'hB0B0;
        @(posedge clk); #1;
        alu_valid = 1'b0; ld_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_w_e3", 64'(w_e3), 64'd0);
        check("midrst_alu_ready", 64'(alu_ready), 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("midrst_after_w_e3", 64'(w_e3), 64'd0);

        repeat (3) @(posedge clk); #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
